// File: rtl/pwm_duty_sequencer_if.sv
// Bundle between the duty sequencer and its surroundings: command/button inputs,
// the PWM core's period_end pulse, and the duty value/strobe back to the core.
interface pwm_duty_sequencer_if #(
   parameter int DUTY_W = 4
);
   logic              ena;
   logic              inc_btn;
   logic              dec_btn;
   logic              start;
   logic              stop;
   logic              period_end;
   logic [DUTY_W-1:0] duty_out;
   logic              duty_load;
   logic              busy;
   logic [1:0]        state;
`ifdef PWM_SEQ_LIMIT_FLAG_EN
   logic              limit_hit;

   modport master (
      output ena, inc_btn, dec_btn, start, stop, period_end,
      input  duty_out, duty_load, busy, state, limit_hit
   );
   modport slave (
      input  ena, inc_btn, dec_btn, start, stop, period_end,
      output duty_out, duty_load, busy, state, limit_hit
   );
`else
   modport master (
      output ena, inc_btn, dec_btn, start, stop, period_end,
      input  duty_out, duty_load, busy, state
   );
   modport slave (
      input  ena, inc_btn, dec_btn, start, stop, period_end,
      output duty_out, duty_load, busy, state
   );
`endif
endinterface

// File: rtl/pwm_duty_sequencer.sv
// Duty sequencer for the 10-step PWM core: debounced inc/dec, soft-start/stop ramp,
// duty changes only at period boundaries. Optional sticky limit flag: PWM_SEQ_LIMIT_FLAG_EN.
module pwm_duty_sequencer #(
   parameter int DUTY_W       = 4,
   parameter int DUTY_MAX     = 9,
   parameter int DUTY_MIN     = 1,
   parameter int DUTY_INIT    = 5,
   parameter int DEB_DIV      = 2,
   parameter int RAMP_PERIODS = 4
) (
   input  logic                clk,
   input  logic                rst_n,
   pwm_duty_sequencer_if.slave bus
);
   localparam int TICK_W = $clog2(DEB_DIV);
   localparam int RAMP_W = (RAMP_PERIODS > 1) ? $clog2(RAMP_PERIODS) : 1;
   localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(DEB_DIV - 1);
   localparam logic [RAMP_W-1:0] RAMP_LAST = RAMP_W'(RAMP_PERIODS - 1);
   localparam logic [DUTY_W-1:0] MAX_V     = DUTY_W'(DUTY_MAX);
   localparam logic [DUTY_W-1:0] MIN_V     = DUTY_W'(DUTY_MIN);
   localparam logic [DUTY_W-1:0] INIT_V    = DUTY_W'(DUTY_INIT);

   typedef enum logic [1:0] {
      S_IDLE    = 2'd0,
      S_RAMP_UP = 2'd1,
      S_RUN     = 2'd2,
      S_RAMP_DN = 2'd3
   } state_t;

   logic [TICK_W-1:0] tick_q;
   logic              inc_s1_q, inc_s2_q, dec_s1_q, dec_s2_q;
   logic              tick_s, inc_ev_s, dec_ev_s, inc_ok_s, dec_ok_s, ramp_due_s;
   logic [DUTY_W-1:0] duty_up_s, duty_dn_s;

   state_t            state_q, state_d;
   logic [DUTY_W-1:0] duty_q, duty_d, target_q, target_d;
   logic [RAMP_W-1:0] ramp_q, ramp_d;
   logic              load_q, load_d, busy_q, busy_d;
   logic              pinc_q, pinc_d, pdec_q, pdec_d;
`ifdef PWM_SEQ_LIMIT_FLAG_EN
   logic              limit_q, limit_d;
`endif

   assign tick_s     = (tick_q == TICK_LAST);
   assign inc_ev_s   = inc_s1_q & ~inc_s2_q & tick_s;
   assign dec_ev_s   = dec_s1_q & ~dec_s2_q & tick_s;
   assign inc_ok_s   = pinc_q & (duty_q < MAX_V);
   assign dec_ok_s   = pdec_q & (duty_q > MIN_V);
   assign ramp_due_s = (ramp_q == RAMP_LAST);
   assign duty_up_s  = duty_q + 1'b1;
   assign duty_dn_s  = duty_q - 1'b1;

   // Button sampling: two-stage shift on each slow debounce tick
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         tick_q   <= '0;
         inc_s1_q <= 1'b0;
         inc_s2_q <= 1'b0;
         dec_s1_q <= 1'b0;
         dec_s2_q <= 1'b0;
      end else if (bus.ena) begin
         tick_q <= tick_s ? '0 : tick_q + 1'b1;
         if (tick_s) begin
            inc_s1_q <= bus.inc_btn;
            inc_s2_q <= inc_s1_q;
            dec_s1_q <= bus.dec_btn;
            dec_s2_q <= dec_s1_q;
         end
      end
   end

   // Next-state logic for the sequencer FSM and its registered outputs
   always_comb begin
      state_d  = state_q;
      duty_d   = duty_q;
      target_d = target_q;
      ramp_d   = ramp_q;
      load_d   = 1'b0;
      pinc_d   = pinc_q;
      pdec_d   = pdec_q;
`ifdef PWM_SEQ_LIMIT_FLAG_EN
      limit_d  = limit_q;
`endif
      case (state_q)
         S_IDLE: begin
            duty_d = '0;
            pinc_d = 1'b0;
            pdec_d = 1'b0;
            if (bus.start && !bus.stop) state_d = S_RAMP_UP;
            else                        state_d = S_IDLE;
         end
         S_RAMP_UP: begin
            if (bus.stop) begin
               state_d = S_RAMP_DN;
            end else if (bus.period_end) begin
               // First boundary after start loads DUTY_MIN, later steps wait RAMP_PERIODS
               if (duty_q == '0) begin
                  duty_d = MIN_V;
                  load_d = 1'b1;
                  ramp_d = '0;
                  if (MIN_V >= target_q) state_d = S_RUN;
                  else                   state_d = S_RAMP_UP;
               end else if (ramp_due_s) begin
                  duty_d = duty_up_s;
                  load_d = 1'b1;
                  ramp_d = '0;
                  if (duty_up_s >= target_q) state_d = S_RUN;
                  else                       state_d = S_RAMP_UP;
               end else begin
                  ramp_d = ramp_q + 1'b1;
               end
            end else begin
               state_d = S_RAMP_UP;
            end
         end
         S_RUN: begin
            if (bus.stop) begin
               state_d = S_RAMP_DN;
            end else if (bus.period_end) begin
               pinc_d = 1'b0;
               pdec_d = 1'b0;
               if (inc_ok_s) begin
                  duty_d   = duty_up_s;
                  target_d = target_q + 1'b1;
                  load_d   = 1'b1;
               end else if (dec_ok_s) begin
                  duty_d   = duty_dn_s;
                  target_d = target_q - 1'b1;
                  load_d   = 1'b1;
               end else begin
                  load_d   = 1'b0;
               end
`ifdef PWM_SEQ_LIMIT_FLAG_EN
               if ((pinc_q && !inc_ok_s) || (pdec_q && !dec_ok_s && !inc_ok_s)) limit_d = 1'b1;
               else                                                             limit_d = limit_q;
`endif
            end else begin
               state_d = S_RUN;
            end
         end
         S_RAMP_DN: begin
            if (duty_q == '0) begin
               state_d = S_IDLE;
            end else if (bus.period_end) begin
               if (ramp_due_s) begin
                  duty_d = duty_dn_s;
                  load_d = 1'b1;
                  ramp_d = '0;
                  if (duty_dn_s == '0) state_d = S_IDLE;
                  else                 state_d = S_RAMP_DN;
               end else begin
                  ramp_d = ramp_q + 1'b1;
               end
            end else begin
               state_d = S_RAMP_DN;
            end
         end
         default: begin
            state_d = S_IDLE;
            duty_d  = '0;
         end
      endcase

      // Requests held through ramps; a same-tick inc+dec pair cancels out
      if (state_q != S_IDLE && inc_ev_s && !dec_ev_s)      pinc_d = 1'b1;
      else if (state_q != S_IDLE && dec_ev_s && !inc_ev_s) pdec_d = 1'b1;
      else                                                 pinc_d = pinc_d;

      if (state_d != state_q) ramp_d = '0;
      else                    ramp_d = ramp_d;
`ifdef PWM_SEQ_LIMIT_FLAG_EN
      if (state_d == S_IDLE) limit_d = 1'b0;
      else                   limit_d = limit_d;
`endif
      busy_d = (state_d == S_RAMP_UP) || (state_d == S_RAMP_DN);
   end

   // Sequencer state register; ena low freezes everything and suppresses the strobe
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= S_IDLE;
         duty_q   <= '0;
         target_q <= INIT_V;
         ramp_q   <= '0;
         load_q   <= 1'b0;
         busy_q   <= 1'b0;
         pinc_q   <= 1'b0;
         pdec_q   <= 1'b0;
`ifdef PWM_SEQ_LIMIT_FLAG_EN
         limit_q  <= 1'b0;
`endif
      end else if (bus.ena) begin
         state_q  <= state_d;
         duty_q   <= duty_d;
         target_q <= target_d;
         ramp_q   <= ramp_d;
         load_q   <= load_d;
         busy_q   <= busy_d;
         pinc_q   <= pinc_d;
         pdec_q   <= pdec_d;
`ifdef PWM_SEQ_LIMIT_FLAG_EN
         limit_q  <= limit_d;
`endif
      end else begin
         load_q   <= 1'b0;
      end
   end

   assign bus.duty_out  = duty_q;
   assign bus.duty_load = load_q;
   assign bus.busy      = busy_q;
   assign bus.state     = state_q;
`ifdef PWM_SEQ_LIMIT_FLAG_EN
   assign bus.limit_hit = limit_q;
`endif
endmodule

// File: doc/pwm_duty_sequencer.md
Name: pwm_duty_sequencer

Overview:
- Controller that sequences the duty-cycle input of the 10-step PWM generator core.
- Debounces the increase/decrease buttons and arbitrates them against a soft-start/soft-stop ramp engine.
- Delivers every duty change to the PWM core only at a PWM period boundary, with a single-cycle load strobe, so no output period is ever glitched.
- Sits between ui_in buttons/commands and the PWM core's DUTY_CYCLE register.

Parameters:
- DUTY_W, 4, width of duty value.
- DUTY_MAX, 9, upper duty limit in RUN.
- DUTY_MIN, 1, lower duty limit in RUN; also the first ramp-up step.
- DUTY_INIT, 5, target duty after reset (50%).
- DEB_DIV, 2, clk cycles per debounce sample tick (≥2).
- RAMP_PERIODS, 4, PWM periods per ramp step (≥1).

Ports:
- clk, input, 1, system clock.
- rst_n, input, 1, asynchronous active-low reset.
- ena, input, 1, high = operate; low = freeze all state, no strobes.
- inc_btn, input, 1, raw increase button.
- dec_btn, input, 1, raw decrease button.
- start, input, 1, level-sampled start command.
- stop, input, 1, level-sampled stop command; has priority over start.
- period_end, input, 1, one-cycle pulse from the PWM core when its counter wraps 9→0.
- duty_out, output, DUTY_W, duty value presented to the PWM core.
- duty_load, output, 1, one-cycle strobe; the core captures duty_out on it.
- busy, output, 1, high in RAMP_UP or RAMP_DN.
- state, output, 2, IDLE=0, RAMP_UP=1, RUN=2, RAMP_DN=3.

Behaviour:
- Reset (async assert, sync release): state=IDLE, duty_out=0, duty_load=0, busy=0, target=DUTY_INIT, tick counter=0, debounce FFs=0, pending flags=0, ramp counter=0.
- Debounce:
  - tick counter counts 0..DEB_DIV-1; tick=1 when count==DEB_DIV-1.
  - On each tick, each button shifts through 2 FFs (s1←raw, s2←s1).
  - A press event is s1 & ~s2 & tick.
  - A press event sets the sticky pending_inc or pending_dec flag.
  - inc and dec events in the same tick cancel; neither flag is set.
- Updates: duty_out changes and duty_load pulses only in the cycle after a period_end pulse, registered one cycle. duty_load is never high for two consecutive cycles.
- IDLE:
  - duty_out=0; pending flags cleared every cycle.
  - start & ~stop → RAMP_UP; duty_out=DUTY_MIN, loaded at the next period_end.
- RAMP_UP:
  - Ramp counter counts period_end pulses; every RAMP_PERIODS pulses, duty_out+=1 with duty_load.
  - When duty_out==target → RUN.
  - If target≤DUTY_MIN, go to RUN after the first load.
  - Button flags are held, not applied.
- RUN:
  - On period_end, pending_inc with duty_out<DUTY_MAX → duty_out+1 and target+1.
  - Else on period_end, pending_dec with duty_out>DUTY_MIN → duty_out-1 and target-1.
  - Both pending flags clear on that period_end, whether or not a change occurred.
  - At a limit, the request is dropped with no strobe.
- stop (any non-IDLE state) → RAMP_DN. Target is retained, so the next start ramps back to the last RUN duty.
- RAMP_DN:
  - Every RAMP_PERIODS period_end pulses, duty_out-=1 with duty_load.
  - Reaching 0 → IDLE.
  - start has no effect until IDLE is reached.
- Arithmetic: unsigned DUTY_W; duty_out never exceeds DUTY_MAX and never wraps below 0.
- Ramp counter resets to 0 on every state change.
- ena=0: all registers hold, duty_load forced 0, period_end and buttons ignored.
- rst_n asserted mid-ramp: immediate return to reset values, including duty_out=0. The core sees duty 0 via the level of duty_out; no strobe is issued.

Optional Feature:
- Macro: PWM_SEQ_LIMIT_FLAG_EN.
- Defined:
  - Adds output limit_hit (1 bit), a sticky flag.
  - Set when a RUN request is dropped because duty_out is at DUTY_MAX (inc) or DUTY_MIN (dec).
  - Cleared by reset or on entering IDLE.
- Undefined: port absent; dropped requests are silently discarded.

Test Plan:
- Reset, start=1, period_end every 10 clk, defaults → duty_out steps 1,2,3,4,5 with duty_load, 4 period_ends per step; state 1→2; busy high during the ramp only.
- RUN at 5, single inc press (held 6 clk) → exactly one duty_load, at the first period_end after debounce; duty_out=6; no change between period_ends.
- RUN at 9, three inc presses → duty_out stays 9, no duty_load; limit_hit=1 when PWM_SEQ_LIMIT_FLAG_EN is defined.
- inc and dec rising in the same debounce tick → no change, no strobe.
- RUN at 7, stop=1 → RAMP_DN: 6,5,...,0 every 4 period_ends, then IDLE. Then start=1 → ramp back up to 7.
- Mid-RAMP_UP (duty 3), rst_n=0 asynchronously between clk edges → duty_out=0, state=IDLE immediately. ena=0 during RUN with period_end pulsing → no duty_load, all state held.
